// File: rtl/bp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bp_pkg
//  Description : Shared definitions for the branch predictor: index-mode
//                encodings and the BTB entry record.  The entry record uses
//                a fixed maximum field width so it can be shared by every
//                parameterisation; narrower entries are zero-extended.
//  Revision    : 1.0 - initial release
// ============================================================================
package bp_pkg;

    localparam int MODE_BIMODAL = 0;
    localparam int MODE_GSHARE  = 1;

    // Widest tag/target a BTB entry can carry (ADDR_W must not exceed this).
    localparam int BP_FIELD_MAX = 32;

    typedef struct packed {
        logic                    valid;
        logic [BP_FIELD_MAX-1:0] tag;
        logic [BP_FIELD_MAX-1:0] target;
    } bp_btb_entry_t;

endpackage : bp_pkg
`default_nettype wire

// File: rtl/bp_btb.sv
`default_nettype none
// ============================================================================
//  Module      : bp_btb
//  Description : Branch target buffer.  Direct-mapped valid/tag/target array
//                with a combinational read port and a clocked write port.
//                Only the valid bits are reset; tag and target contents are
//                meaningless until the matching valid bit is set.
//  Ports       : clk, rst           - clock, async active-high reset
//                i_rd_idx           - lookup index
//                o_rd_entry         - entry at i_rd_idx (zero-extended fields)
//                i_wr_en            - write strobe
//                i_wr_idx/tag/target- entry written on a strobed edge
//  Revision    : 1.0 - initial release
// ============================================================================
module bp_btb
    import bp_pkg::*;
#(
    parameter  int ADDR_W  = 12,
    parameter  int ENTRIES = 64,
    localparam int IDX_W   = $clog2(ENTRIES),
    localparam int TAG_W   = ADDR_W - IDX_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [IDX_W-1:0]    i_rd_idx,
    output bp_btb_entry_t       o_rd_entry,
    input  logic                i_wr_en,
    input  logic [IDX_W-1:0]    i_wr_idx,
    input  logic [TAG_W-1:0]    i_wr_tag,
    input  logic [ADDR_W-1:0]   i_wr_target
);

    logic [ENTRIES-1:0] r_valid;
    logic [TAG_W-1:0]   r_tag    [ENTRIES];
    logic [ADDR_W-1:0]  r_target [ENTRIES];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
        end else if (i_wr_en) begin
            r_valid[i_wr_idx] <= 1'b1;
        end
    end

    // Payload is not reset, but a write presented while reset is held is
    // still dropped so the array never changes under reset.
    always_ff @(posedge clk) begin
        if (i_wr_en && !rst) begin
            r_tag[i_wr_idx]    <= i_wr_tag;
            r_target[i_wr_idx] <= i_wr_target;
        end
    end

    always_comb begin
        o_rd_entry        = '0;
        o_rd_entry.valid  = r_valid[i_rd_idx];
        o_rd_entry.tag    = BP_FIELD_MAX'(r_tag[i_rd_idx]);
        o_rd_entry.target = BP_FIELD_MAX'(r_target[i_rd_idx]);
    end

endmodule : bp_btb
`default_nettype wire

// File: rtl/branch_predictor.sv
`default_nettype none
// ============================================================================
//  Module      : branch_predictor
//  Description : Bimodal / gshare direction predictor with a direct-mapped
//                BTB.  Lookup is purely combinational from registered state;
//                updates from resolved branches land on the rising clock edge
//                and are visible from the following cycle (no bypass).
//  Ports       : clock, reset                 - clock, async active-high reset
//                fetch_pc                     - PC being fetched
//                pred_taken/target/hit/idx    - prediction for fetch_pc
//                upd_valid/pc/idx/taken/target/mispredict - resolved branch
//                stat_branches/stat_mispredicts - wrapping 32-bit statistics
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_predictor
    import bp_pkg::*;
#(
    parameter  int ADDR_W  = 12,
    parameter  int ENTRIES = 64,
    parameter  int CTR_W   = 2,
    parameter  int HIST_W  = 6,
    parameter  int MODE    = MODE_BIMODAL,
    localparam int IDX_W   = $clog2(ENTRIES)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   fetch_pc,
    output logic                pred_taken,
    output logic [ADDR_W-1:0]   pred_target,
    output logic                pred_hit,
    output logic [IDX_W-1:0]    pred_idx,
    input  logic                upd_valid,
    input  logic [ADDR_W-1:0]   upd_pc,
    input  logic [IDX_W-1:0]    upd_idx,
    input  logic                upd_taken,
    input  logic [ADDR_W-1:0]   upd_target,
    input  logic                upd_mispredict,
    output logic [31:0]         stat_branches,
    output logic [31:0]         stat_mispredicts
);

    localparam int               c_TAG_W    = ADDR_W - IDX_W;
    // Weakly not-taken; evaluates to 0 for a 1-bit counter.
    localparam logic [CTR_W-1:0] c_CTR_INIT = CTR_W'((1 << (CTR_W - 1)) - 1);
    localparam logic [CTR_W-1:0] c_CTR_MAX  = '1;

    logic [CTR_W-1:0]   r_ctr [ENTRIES];
    logic [HIST_W-1:0]  r_ghr;
    logic [31:0]        r_stat_br;
    logic [31:0]        r_stat_mp;

    logic [IDX_W-1:0]   w_idx;
    logic [c_TAG_W-1:0] w_fetch_tag;
    bp_btb_entry_t      w_btb_rd;
    logic               w_hit;
    logic               w_btb_we;
    logic               w_unused_btb;

    // ------------------------------------------------------------------
    // Counter index selection
    // ------------------------------------------------------------------
    generate
        if (MODE == MODE_GSHARE) begin : g_gshare_idx
            assign w_idx = fetch_pc[IDX_W-1:0] ^ IDX_W'(r_ghr);
        end else begin : g_bimodal_idx
            assign w_idx = fetch_pc[IDX_W-1:0];
        end
    endgenerate

    // ------------------------------------------------------------------
    // BTB
    // ------------------------------------------------------------------
    assign w_btb_we = upd_valid && upd_taken;

    bp_btb #(
        .ADDR_W      (ADDR_W),
        .ENTRIES     (ENTRIES)
    ) u_btb (
        .clk         (clock),
        .rst         (reset),
        .i_rd_idx    (fetch_pc[IDX_W-1:0]),
        .o_rd_entry  (w_btb_rd),
        .i_wr_en     (w_btb_we),
        .i_wr_idx    (upd_pc[IDX_W-1:0]),
        .i_wr_tag    (upd_pc[ADDR_W-1:IDX_W]),
        .i_wr_target (upd_target)
    );

    assign w_fetch_tag = fetch_pc[ADDR_W-1:IDX_W];
    // Stored tags are zero-extended, so a full-width compare is exact.
    assign w_hit       = w_btb_rd.valid &&
                         (w_btb_rd.tag == BP_FIELD_MAX'(w_fetch_tag));
    // Upper target bits above ADDR_W are always zero.
    assign w_unused_btb = ^w_btb_rd;

    // ------------------------------------------------------------------
    // Prediction outputs
    // ------------------------------------------------------------------
    assign pred_idx    = w_idx;
    assign pred_hit    = w_hit;
    assign pred_taken  = r_ctr[w_idx][CTR_W-1] & w_hit;
    assign pred_target = pred_taken ? w_btb_rd.target[ADDR_W-1:0]
                                    : fetch_pc + 1'b1;

    // ------------------------------------------------------------------
    // Saturating counter table
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_ctr[i] <= c_CTR_INIT;
            end
        end else if (upd_valid) begin
            if (upd_taken && (r_ctr[upd_idx] != c_CTR_MAX)) begin
                r_ctr[upd_idx] <= r_ctr[upd_idx] + 1'b1;
            end else if (!upd_taken && (r_ctr[upd_idx] != '0)) begin
                r_ctr[upd_idx] <= r_ctr[upd_idx] - 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Global history (resolved outcomes only) and statistics
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_ghr     <= '0;
            r_stat_br <= '0;
            r_stat_mp <= '0;
        end else if (upd_valid) begin
            r_ghr     <= HIST_W'({r_ghr, upd_taken});
            r_stat_br <= r_stat_br + 32'd1;
            if (upd_mispredict) begin
                r_stat_mp <= r_stat_mp + 32'd1;
            end
        end
    end

    assign stat_branches    = r_stat_br;
    assign stat_mispredicts = r_stat_mp;

endmodule : branch_predictor
`default_nettype wire

// File: tb/tb_branch_predictor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_branch_predictor
//  Description : Directed self-checking bench.  Two instances share every
//                input: u_dut0 in bimodal mode, u_dut1 in gshare mode.
//                Observed tuples are {taken, hit, target[11:0], idx[5:0]}.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_predictor;

    logic        clock = 1'b0;
    logic        reset;
    logic [11:0] fetch_pc;
    logic        upd_valid;
    logic [11:0] upd_pc;
    logic [5:0]  upd_idx;
    logic        upd_taken;
    logic [11:0] upd_target;
    logic        upd_mispredict;

    logic        p0_taken, p0_hit, p1_taken, p1_hit;
    logic [11:0] p0_target, p1_target;
    logic [5:0]  p0_idx, p1_idx;
    logic [31:0] s0_br, s0_mp, s1_br, s1_mp;

    logic [19:0] got0, got1;
    assign got0 = {p0_taken, p0_hit, p0_target, p0_idx};
    assign got1 = {p1_taken, p1_hit, p1_target, p1_idx};

    int n_vec = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    branch_predictor #(.ADDR_W(12), .ENTRIES(64), .CTR_W(2), .HIST_W(6), .MODE(0)) u_dut0 (
        .clock(clock), .reset(reset), .fetch_pc(fetch_pc),
        .pred_taken(p0_taken), .pred_target(p0_target), .pred_hit(p0_hit), .pred_idx(p0_idx),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_idx(upd_idx), .upd_taken(upd_taken),
        .upd_target(upd_target), .upd_mispredict(upd_mispredict),
        .stat_branches(s0_br), .stat_mispredicts(s0_mp)
    );

    branch_predictor #(.ADDR_W(12), .ENTRIES(64), .CTR_W(2), .HIST_W(6), .MODE(1)) u_dut1 (
        .clock(clock), .reset(reset), .fetch_pc(fetch_pc),
        .pred_taken(p1_taken), .pred_target(p1_target), .pred_hit(p1_hit), .pred_idx(p1_idx),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_idx(upd_idx), .upd_taken(upd_taken),
        .upd_target(upd_target), .upd_mispredict(upd_mispredict),
        .stat_branches(s1_br), .stat_mispredicts(s1_mp)
    );

    // Stimulus helpers (no checking inside)
    task automatic drive_update(input logic [11:0] pc, input logic [5:0] idx,
                                input logic taken, input logic [11:0] tgt,
                                input logic mp);
        @(negedge clock);
        upd_valid = 1'b1; upd_pc = pc; upd_idx = idx;
        upd_taken = taken; upd_target = tgt; upd_mispredict = mp;
        @(posedge clock); #1;
        upd_valid = 1'b0; upd_mispredict = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clock); reset = 1'b1;
        @(posedge clock);
        @(negedge clock); reset = 1'b0;
    endtask

    task automatic set_fetch(input logic [11:0] pc);
        @(negedge clock); fetch_pc = pc; #1;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        #2;
        n_vec++; if (got0 !== {1'b0, 1'b0, 12'h011, 6'h10}) begin n_err++;
            $display("FAIL reset_during_dut0 got %h want %h", got0, {1'b0, 1'b0, 12'h011, 6'h10}); end
        n_vec++; if (got1 !== {1'b0, 1'b0, 12'h011, 6'h10}) begin n_err++;
            $display("FAIL reset_during_dut1 got %h want %h", got1, {1'b0, 1'b0, 12'h011, 6'h10}); end
        n_vec++; if ({s0_br, s0_mp} !== 64'd0) begin n_err++;
            $display("FAIL reset_stats got br=%0d mp=%0d want 0 0", s0_br, s0_mp); end
        @(posedge clock);
        @(negedge clock); reset = 1'b0; #1;
        n_vec++; if (got0 !== {1'b0, 1'b0, 12'h011, 6'h10}) begin n_err++;
            $display("FAIL reset_after_dut0 got %h want %h", got0, {1'b0, 1'b0, 12'h011, 6'h10}); end
    endtask

    task automatic test_single_taken();
        drive_update(12'h010, 6'h10, 1'b1, 12'h020, 1'b1);
        set_fetch(12'h010);
        n_vec++; if (got0 !== {1'b1, 1'b1, 12'h020, 6'h10}) begin n_err++;
            $display("FAIL single_taken got %h want %h", got0, {1'b1, 1'b1, 12'h020, 6'h10}); end
        n_vec++; if ({s0_br, s0_mp} !== {32'd1, 32'd1}) begin n_err++;
            $display("FAIL single_stats got br=%0d mp=%0d want 1 1", s0_br, s0_mp); end
    endtask

    task automatic test_alias();
        set_fetch(12'h050);
        n_vec++; if (got0 !== {1'b0, 1'b0, 12'h051, 6'h10}) begin n_err++;
            $display("FAIL alias_tag got %h want %h", got0, {1'b0, 1'b0, 12'h051, 6'h10}); end
        set_fetch(12'h011);
        n_vec++; if (got0 !== {1'b0, 1'b0, 12'h012, 6'h11}) begin n_err++;
            $display("FAIL neighbour_idx got %h want %h", got0, {1'b0, 1'b0, 12'h012, 6'h11}); end
        set_fetch(12'hFFF);
        n_vec++; if (got0 !== {1'b0, 1'b0, 12'h000, 6'h3F}) begin n_err++;
            $display("FAIL pc_wrap got %h want %h", got0, {1'b0, 1'b0, 12'h000, 6'h3F}); end
    endtask

    task automatic test_hysteresis();
        apply_reset();
        for (int k = 0; k < 5; k++) drive_update(12'h010, 6'h10, 1'b1, 12'h020, 1'b0);
        drive_update(12'h010, 6'h10, 1'b0, 12'h000, 1'b1);
        set_fetch(12'h010);
        n_vec++; if (got0 !== {1'b1, 1'b1, 12'h020, 6'h10}) begin n_err++;
            $display("FAIL hyst_one_nt got %h want %h", got0, {1'b1, 1'b1, 12'h020, 6'h10}); end
        drive_update(12'h010, 6'h10, 1'b0, 12'h000, 1'b1);
        set_fetch(12'h010);
        n_vec++; if (got0 !== {1'b0, 1'b1, 12'h011, 6'h10}) begin n_err++;
            $display("FAIL hyst_two_nt got %h want %h", got0, {1'b0, 1'b1, 12'h011, 6'h10}); end
        n_vec++; if ({s0_br, s0_mp} !== {32'd7, 32'd2}) begin n_err++;
            $display("FAIL hyst_stats got br=%0d mp=%0d want 7 2", s0_br, s0_mp); end
        // mispredict flag without valid must not count
        @(negedge clock); upd_mispredict = 1'b1;
        @(posedge clock); #1; upd_mispredict = 1'b0;
        n_vec++; if ({s0_br, s0_mp} !== {32'd7, 32'd2}) begin n_err++;
            $display("FAIL idle_mispredict got br=%0d mp=%0d want 7 2", s0_br, s0_mp); end
        // counter 1 -> 0 -> 0 (saturate) -> 1: still not taken
        drive_update(12'h010, 6'h10, 1'b0, 12'h000, 1'b0);
        drive_update(12'h010, 6'h10, 1'b0, 12'h000, 1'b0);
        drive_update(12'h010, 6'h10, 1'b1, 12'h020, 1'b0);
        set_fetch(12'h010);
        n_vec++; if (got0 !== {1'b0, 1'b1, 12'h011, 6'h10}) begin n_err++;
            $display("FAIL sat_low got %h want %h", got0, {1'b0, 1'b1, 12'h011, 6'h10}); end
        drive_update(12'h010, 6'h10, 1'b1, 12'h030, 1'b0);
        set_fetch(12'h010);
        n_vec++; if (got0 !== {1'b1, 1'b1, 12'h030, 6'h10}) begin n_err++;
            $display("FAIL btb_overwrite got %h want %h", got0, {1'b1, 1'b1, 12'h030, 6'h10}); end
    endtask

    task automatic test_same_cycle();
        apply_reset();
        @(negedge clock);
        fetch_pc = 12'h010;
        upd_valid = 1'b1; upd_pc = 12'h010; upd_idx = 6'h10;
        upd_taken = 1'b1; upd_target = 12'h020; upd_mispredict = 1'b0;
        #1;
        n_vec++; if (got0 !== {1'b0, 1'b0, 12'h011, 6'h10}) begin n_err++;
            $display("FAIL same_cycle_old got %h want %h", got0, {1'b0, 1'b0, 12'h011, 6'h10}); end
        @(posedge clock); #1; upd_valid = 1'b0;
        n_vec++; if (got0 !== {1'b1, 1'b1, 12'h020, 6'h10}) begin n_err++;
            $display("FAIL same_cycle_new got %h want %h", got0, {1'b1, 1'b1, 12'h020, 6'h10}); end
    endtask

    task automatic test_reset_discard();
        @(negedge clock);
        reset = 1'b1;
        upd_valid = 1'b1; upd_pc = 12'h020; upd_idx = 6'h20;
        upd_taken = 1'b1; upd_target = 12'h040; upd_mispredict = 1'b1;
        @(posedge clock); #1; upd_valid = 1'b0; upd_mispredict = 1'b0;
        @(negedge clock); reset = 1'b0;
        set_fetch(12'h020);
        n_vec++; if (got0 !== {1'b0, 1'b0, 12'h021, 6'h20}) begin n_err++;
            $display("FAIL discard_btb got %h want %h", got0, {1'b0, 1'b0, 12'h021, 6'h20}); end
        set_fetch(12'h010);
        n_vec++; if (got0 !== {1'b0, 1'b0, 12'h011, 6'h10}) begin n_err++;
            $display("FAIL discard_prior got %h want %h", got0, {1'b0, 1'b0, 12'h011, 6'h10}); end
        n_vec++; if ({s0_br, s0_mp} !== 64'd0) begin n_err++;
            $display("FAIL discard_stats got br=%0d mp=%0d want 0 0", s0_br, s0_mp); end
    endtask

    task automatic test_gshare();
        apply_reset();
        drive_update(12'h010, 6'h10, 1'b1, 12'h020, 1'b0);
        drive_update(12'h030, 6'h20, 1'b0, 12'h000, 1'b0);
        set_fetch(12'h010);
        n_vec++; if (got1 !== {1'b0, 1'b1, 12'h011, 6'h12}) begin n_err++;
            $display("FAIL gshare_idx got %h want %h", got1, {1'b0, 1'b1, 12'h011, 6'h12}); end
        n_vec++; if (got0 !== {1'b1, 1'b1, 12'h020, 6'h10}) begin n_err++;
            $display("FAIL bimodal_same got %h want %h", got0, {1'b1, 1'b1, 12'h020, 6'h10}); end
        n_vec++; if (s1_br !== 32'd2) begin n_err++;
            $display("FAIL gshare_stats got %0d want 2", s1_br); end
        #1 reset = 1'b1;
        #1;
        n_vec++; if (got1 !== {1'b0, 1'b0, 12'h011, 6'h10}) begin n_err++;
            $display("FAIL async_reset got %h want %h", got1, {1'b0, 1'b0, 12'h011, 6'h10}); end
        n_vec++; if (s1_br !== 32'd0) begin n_err++;
            $display("FAIL async_reset_stats got %0d want 0", s1_br); end
        @(posedge clock);
        @(negedge clock); reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; fetch_pc = 12'h010;
        upd_valid = 1'b0; upd_pc = '0; upd_idx = '0;
        upd_taken = 1'b0; upd_target = '0; upd_mispredict = 1'b0;
        test_reset();
        test_single_taken();
        test_alias();
        test_hysteresis();
        test_same_cycle();
        test_reset_discard();
        test_gshare();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_branch_predictor
`default_nettype wire

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 Parameter ADDR_W, 12, PC/word-address width; matches imem address width.
REQ-002 Parameter ENTRIES, 64, counter-table and BTB depth; power of 2, 4..1024; IDX_W = log2(ENTRIES).
REQ-003 Parameter CTR_W, 2, saturating-counter width; 1..4.
REQ-004 Parameter HIST_W, 6, global-history width; 1..IDX_W.
REQ-005 Parameter MODE, 0, index mode: 0 = bimodal, 1 = gshare.
REQ-006 Port clock  in  1  master clock; all state updates on its rising edge.
REQ-007 Port reset  in  1  reset, asynchronous, active-high.
REQ-008 Port fetch_pc  in  ADDR_W  PC being fetched.
REQ-009 Port pred_taken  out  1  predicted taken.
REQ-010 Port pred_target  out  ADDR_W  predicted next PC.
REQ-011 Port pred_hit  out  1  BTB valid and tag match for fetch_pc.
REQ-012 Port pred_idx  out  IDX_W  counter index used; carried down the pipe.
REQ-013 Port upd_valid  in  1  resolved branch this cycle.
REQ-014 Port upd_pc  in  ADDR_W  resolved branch PC.
REQ-015 Port upd_idx  in  IDX_W  pred_idx returned with that branch.
REQ-016 Port upd_taken  in  1  actual outcome.
REQ-017 Port upd_target  in  ADDR_W  actual taken target.
REQ-018 Port upd_mispredict  in  1  resolved outcome or target differed from prediction.
REQ-019 Port stat_branches  out  32  count of upd_valid cycles.
REQ-020 Port stat_mispredicts  out  32  count of upd_valid && upd_mispredict cycles.

Function
REQ-021 Lookup is combinational from registered state: zero-cycle latency from fetch_pc to pred_*.
REQ-022 Counter index: MODE 0 -> fetch_pc[IDX_W-1:0]; MODE 1 -> fetch_pc[IDX_W-1:0] XOR zero-extended GHR.
REQ-023 BTB index is always fetch_pc[IDX_W-1:0]; tag = fetch_pc[ADDR_W-1:IDX_W].
REQ-024 pred_taken = counter[pred_idx] MSB AND pred_hit.
REQ-025 pred_target = BTB target when pred_taken, else fetch_pc + 1, truncated to ADDR_W (wraps at all-ones).
REQ-026 On an edge with upd_valid: counter[upd_idx] increments if upd_taken, else decrements; saturates at 0 and 2^CTR_W-1.
REQ-027 On an edge with upd_valid && upd_taken: BTB[upd_pc low bits] <= {valid=1, tag of upd_pc, upd_target}; overwrites any prior entry.
REQ-028 Not-taken updates never invalidate or modify a BTB entry.
REQ-029 On an edge with upd_valid: GHR <= {GHR[HIST_W-2:0], upd_taken} (non-speculative history).
REQ-030 Update is visible to lookup from the cycle after the edge; a same-cycle lookup of the updated entry returns pre-update state (no bypass).
REQ-031 Tag mismatch on a shared index: pred_hit=0, pred_taken=0, counter still shared (aliasing permitted).
REQ-032 Stat counters increment per REQ-019/020 and wrap 0xFFFFFFFF -> 0.
REQ-033 upd_mispredict is ignored when upd_valid=0.

Reset
REQ-034 reset asserted forces state immediately, independent of clock: all counters = 2^(CTR_W-1)-1 (weakly not-taken; 0 when CTR_W=1), all BTB valid = 0, GHR = 0, stat counters = 0.
REQ-035 During and after reset until first update: pred_taken=0, pred_hit=0, pred_target=fetch_pc+1, pred_idx=fetch_pc[IDX_W-1:0].
REQ-036 Reset asserted mid-run discards any update presented in that cycle.

Structure
REQ-037 Shared package bp_pkg holds MODE_BIMODAL=0, MODE_GSHARE=1 and the BTB entry struct {valid, tag, target}.
REQ-038 One sub-module, bp_btb: tag/valid/target array with combinational read and clocked write.
REQ-039 Counter table, GHR and stat counters live in branch_predictor.

Verification (defaults unless stated)
REQ-040 Reset, fetch_pc=0x010 -> pred_taken=0, pred_hit=0, pred_target=0x011, stats=0.
REQ-041 One update pc=0x010 taken target=0x020, then fetch 0x010 -> pred_hit=1, pred_taken=1, pred_target=0x020; stat_branches=1.
REQ-042 Five taken updates then one not-taken at 0x010 -> still taken; second not-taken -> pred_taken=0, pred_hit=1.
REQ-043 After REQ-041, fetch 0x050 (same index 0x10, different tag) -> pred_hit=0, pred_taken=0, pred_target=0x051.
REQ-044 Same-cycle update and lookup of 0x010 from reset state -> pred_taken=0 that cycle, 1 next cycle.
REQ-045 MODE=1: updates taken,not-taken (GHR=0b000010), fetch 0x010 -> pred_idx=0x12; async reset mid-cycle -> outputs return to REQ-035 values before next edge.
